// File: rtl/hilo_muldiv_unit_if.sv
// Core <-> HI/LO multiply/divide unit bus: op/start request, busy/done/dbz status, HI/LO readback.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ena;
  logic [2:0]       op;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output ena, op, start, a, b, input busy, done, dbz, hi, lo);
  modport slave  (input ena, op, start, a, b, output busy, done, dbz, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Optional macro EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
module hilo_muldiv_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic                clk,
  input  logic                rst,
  hilo_muldiv_unit_if.slave   core_if
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x, input logic sgn);
    return (sgn && x < 0) ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_mul_q, neg_q, negr_q, divz_q;
  logic [WIDTH-1:0]   a_q, mplier_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;

  logic               arith_op, signed_op, mul_op, run_last;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc_d, mcand_d;
  logic [WIDTH-1:0]   mplier_d;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign mul_op    = (core_if.op == OP_MULT) || (core_if.op == OP_MULTU);
  assign signed_op = (core_if.op == OP_MULT) || (core_if.op == OP_DIV);
  assign arith_op  = mul_op || (core_if.op == OP_DIV) || (core_if.op == OP_DIVU);
  assign a_abs     = abs_w(core_if.a, signed_op);
  assign b_abs     = abs_w(core_if.b, signed_op);

  // Step: shift-add on a widening multiplicand, or restoring subtract on {rem, quotient}
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, mplier_q};
    if (is_mul_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (!rem_diff[WIDTH]) begin
      acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef EARLY_OUT_EN
  assign run_last = (cnt_q == CW'(1)) || (is_mul_q && (mplier_d == '0));
`else
  assign run_last = (cnt_q == CW'(1));
`endif

  // Sign fix-up stage: magnitudes from the datapath become signed results
  always_comb begin
    prod_fix = neg_2w(acc_q, neg_q);
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (!is_mul_q) begin
      res_hi = divz_q ? a_q : neg_w(acc_q[2*WIDTH-1:WIDTH], negr_q);
      res_lo = divz_q ? '1  : neg_w(acc_q[WIDTH-1:0], neg_q);
    end
  end

  // Operand/datapath registers carry no reset; the FSM ignores them until a start
  always_ff @(posedge clk) begin
    if (core_if.ena) begin
      if (state_q == S_IDLE && core_if.start && arith_op) begin
        is_mul_q <= mul_op;
        a_q      <= core_if.a;
        divz_q   <= !mul_op && (core_if.b == '0);
        neg_q    <= signed_op && (core_if.a[WIDTH-1] ^ core_if.b[WIDTH-1]);
        negr_q   <= signed_op && core_if.a[WIDTH-1];
        mplier_q <= b_abs;
        mcand_q  <= {{WIDTH{1'b0}}, a_abs};
        acc_q    <= mul_op ? '0 : {{WIDTH{1'b0}}, a_abs};
      end else if (state_q == S_RUN) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
    end else if (core_if.ena) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (core_if.start && arith_op) begin
            state_q <= S_RUN;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
          end else if (core_if.start && core_if.op == OP_MTHI) begin
            hi_q <= core_if.a;
          end else if (core_if.start && core_if.op == OP_MTLO) begin
            lo_q <= core_if.a;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (run_last) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          dbz_q   <= divz_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_if.busy = busy_q;
  assign core_if.done = done_q;
  assign core_if.dbz  = dbz_q;
  assign core_if.hi   = hi_q;
  assign core_if.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
  localparam int W = 32;
  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
`ifdef EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus();

  hilo_muldiv_unit #(.WIDTH(W), .HILO_RST('0)) dut (
    .clk     (clk),
    .rst     (rst),
    .core_if (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int lat, busy_cyc;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_cnt();
    busy_cyc += int'(bus.busy);
    tick();
    lat++;
  endtask

  // Reference: full-width products and C-style truncating division
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {m_hi, m_lo};
    case (op)
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_MULT:  r = sa * sb;
      OP_DIVU, OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (op == OP_DIVU) r = {a % b, a / b};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    int bl;
    logic [31:0] m;
    m  = (op == OP_MULT && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    if (EARLY && (op == OP_MULT || op == OP_MULTU)) return ((bl < 1) ? 1 : bl) + 1;
    return W + 1;
  endfunction

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    bus.a     = $urandom;
    bus.b     = $urandom;
    chk("busy_at_start", bus.busy, 1);
    chk("dbz_at_start", bus.dbz, 0);
    lat      = 0;
    busy_cyc = 0;
  endtask

  task automatic finish(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int extra, input string tag);
    logic [63:0] r;
    r = model(op, a, b);
    while (!bus.done && lat < 200) step_cnt();
    chk({tag, "_latency"}, lat, exp_lat(op, b) + extra);
    chk({tag, "_busy_cycles"}, busy_cyc, exp_lat(op, b) + extra);
    chk({tag, "_hi"}, bus.hi, r[63:32]);
    chk({tag, "_lo"}, bus.lo, r[31:0]);
    chk({tag, "_dbz"}, bus.dbz, ((op == OP_DIV || op == OP_DIVU) && b == 0) ? 1 : 0);
    m_hi = r[63:32];
    m_lo = r[31:0];
    tick();
    chk({tag, "_done_one_cycle"}, bus.done, 0);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input string tag);
    launch(op, a, b);
    finish(op, a, b, 0, tag);
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a, input string tag);
    bus.op    = op;
    bus.a     = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    if (op == OP_MTHI) m_hi = a;
    if (op == OP_MTLO) m_lo = a;
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0] op;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.ena = 1'b1; bus.start = 1'b0; bus.op = OP_NONE; bus.a = '0; bus.b = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);

    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run(OP_DIVU, 32'd7, 32'd0, "divu_by0");
    run(OP_DIVU, 32'd7, 32'd2, "divu_7by2");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run(OP_DIV, 32'hFFFF_FFF9, 32'd0, "div_by0");
    run(OP_MULTU, 32'd3, 32'd1, "multu_3x1");
    run(OP_MULT, 32'h1234_5678, 32'hFFFF_FF00, "mult_negb");
    move(OP_MTHI, 32'h1234_5678, "mthi");
    move(OP_MTLO, 32'hCAFE_F00D, "mtlo");
    move(3'd7, 32'hDEAD_BEEF, "unknown_op");
    move(OP_NONE, 32'hDEAD_BEEF, "none_op");

    // Starts while busy must be ignored
    launch(OP_MULTU, 32'h0001_0003, 32'h8000_0007);
    repeat (3) step_cnt();
    bus.op = OP_MTLO; bus.a = 32'hDEAD_BEEF; bus.start = 1'b1;
    step_cnt();
    bus.op = OP_MULTU; bus.a = 32'd1; bus.b = 32'd1;
    step_cnt();
    bus.start = 1'b0; bus.op = OP_NONE;
    finish(OP_MULTU, 32'h0001_0003, 32'h8000_0007, 0, "ignore_midbusy");

    // Clock-enable stall mid-RUN
    launch(OP_DIVU, 32'hF00D_1234, 32'd12345);
    repeat (4) step_cnt();
    bus.ena = 1'b0;
    repeat (5) step_cnt();
    bus.ena = 1'b1;
    finish(OP_DIVU, 32'hF00D_1234, 32'd12345, 5, "ena_stall");

    // Reset mid-operation aborts with no done
    launch(OP_MULT, 32'h8765_4321, 32'h8000_0001);
    repeat (10) step_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_done", bus.done, 0);
    m_hi = '0; m_lo = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen += int'(bus.done);
    end
    chk("abort_no_done_later", seen, 0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      if (op == OP_MTHI || op == OP_MTLO) move(op, ra, "rand_move");
      else run(op, ra, rb, "rand_arith");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
